audio_dac_serializer: RTL and testbench

Streams 16-bit stereo sample pairs to the WM8731 codec DAC over its digital audio interface, in left-justified, MSB-first, 16-bit format with the codec as slave. It sits downstream of the codec I2C configuration stage: it stays idle until that stage reports configuration complete, then generates AUD_XCK, AUD_BCLK, AUD_DACLRCK and AUD_DACDAT. It accepts samples from the tone generator through a one-deep valid/ready buffer.

---
 rtl/audio_dac_serializer.sv | 168 ++++++++++++++++
 tb/tb_audio_dac_serializer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/audio_dac_serializer.sv
// WM8731 DAC serializer: left-justified, MSB-first, 16-bit stereo, codec as slave.
// Streams {L,R} pairs taken from a one-deep valid/ready buffer once the codec is configured.
module audio_dac_serializer #(
  parameter int unsigned BCLK_DIV = 12
) (
  input  logic        CLOCK_27,
  input  logic        KEY0,
  input  logic        en,
  input  logic [15:0] sample_l,
  input  logic [15:0] sample_r,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        underrun,
  output logic        AUD_XCK,
  output logic        AUD_BCLK,
  output logic        AUD_DACLRCK,
  output logic        AUD_DACDAT
);

  localparam int unsigned DW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic          first_q, first_d;
  logic [DW-1:0] div_q, div_d;
  logic [4:0]    bit_q, bit_d;
  logic [31:0]   sh_q, sh_d;
  logic [31:0]   buf_q, buf_d;
  logic          full_q, full_d;
  logic          xck_q, xck_d;
  logic          bclk_q, bclk_d;
  logic          lrck_q, lrck_d;
  logic          dat_q, dat_d;
  logic          und_q, und_d;
  logic          rdy_q, rdy_d;

  logic terminal, load, accept;

  always_comb begin
    state_d  = state_q;
    first_d  = first_q;
    div_d    = div_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    buf_d    = buf_q;
    full_d   = full_q;
    xck_d    = xck_q;
    bclk_d   = bclk_q;
    lrck_d   = lrck_q;
    dat_d    = dat_q;
    und_d    = 1'b0;
    load     = 1'b0;
    terminal = (div_q == DW'(BCLK_DIV - 1));
    accept   = sample_valid & rdy_q;

    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = RUN;
          first_d = 1'b1;
        end
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
          first_d = 1'b0;
          div_d   = '0;
          bit_d   = '0;
          sh_d    = '0;
          buf_d   = '0;
          full_d  = 1'b0;
          xck_d   = 1'b0;
          bclk_d  = 1'b0;
          lrck_d  = 1'b0;
          dat_d   = 1'b0;
        end else begin
          xck_d = ~xck_q;
          // The first RUN cycle is a frame load so the handshake sees ready=1 beforehand.
          if (first_q) begin
            first_d = 1'b0;
            load    = 1'b1;
          end else begin
            if (terminal) begin
              div_d  = '0;
              bclk_d = ~bclk_q;
            end else begin
              div_d = div_q + 1'b1;
            end
            if (terminal && bclk_q) begin
              if (bit_q == 5'd31) begin
                load = 1'b1;
              end else begin
                bit_d  = bit_q + 5'd1;
                sh_d   = {sh_q[30:0], 1'b0};
                dat_d  = sh_q[30];
                lrck_d = ~bit_d[4];
              end
            end
          end

          if (load) begin
            div_d  = '0;
            bclk_d = 1'b0;
            bit_d  = '0;
            lrck_d = 1'b1;
            if (full_q) begin
              sh_d   = buf_q;
              full_d = 1'b0;
            end else if (sample_valid) begin
              sh_d = {sample_l, sample_r};
            end else begin
              sh_d  = '0;
              und_d = 1'b1;
            end
            dat_d = sh_d[31];
          end else if (accept) begin
            buf_d  = {sample_l, sample_r};
            full_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    rdy_d = (state_d == RUN) & ~full_d;
  end

  always_ff @(posedge CLOCK_27 or negedge KEY0) begin
    if (!KEY0) begin
      state_q <= IDLE;
      first_q <= 1'b0;
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      buf_q   <= '0;
      full_q  <= 1'b0;
      xck_q   <= 1'b0;
      bclk_q  <= 1'b0;
      lrck_q  <= 1'b0;
      dat_q   <= 1'b0;
      und_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      buf_q   <= buf_d;
      full_q  <= full_d;
      xck_q   <= xck_d;
      bclk_q  <= bclk_d;
      lrck_q  <= lrck_d;
      dat_q   <= dat_d;
      und_q   <= und_d;
      rdy_q   <= rdy_d;
    end
  end

  assign sample_ready = rdy_q;
  assign underrun     = und_q;
  assign AUD_XCK      = xck_q;
  assign AUD_BCLK     = bclk_q;
  assign AUD_DACLRCK  = lrck_q;
  assign AUD_DACDAT   = dat_q;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Directed bench for audio_dac_serializer at BCLK_DIV=12 (768-cycle frames).
module tb_audio_dac_serializer;

  logic        clk = 1'b0;
  logic        rst_n, en, sv;
  logic [15:0] sl, sr;
  logic        ready, und_o, xck, bclk, lrck, dat;
  logic [5:0]  outs;

  int errors = 0;
  int checks = 0;
  int n_acc  = 0;
  bit autoinc = 1'b0;
  bit oneshot = 1'b0;

  logic [31:0] cap;
  int lrn, und, nb, fr, rlo, acc, idle_bad;

  always #5 clk = ~clk;

  assign outs = {xck, bclk, lrck, dat, und_o, ready};

  audio_dac_serializer #(.BCLK_DIV(12)) dut (
    .CLOCK_27     (clk),
    .KEY0         (rst_n),
    .en           (en),
    .sample_l     (sl),
    .sample_r     (sr),
    .sample_valid (sv),
    .sample_ready (ready),
    .underrun     (und_o),
    .AUD_XCK      (xck),
    .AUD_BCLK     (bclk),
    .AUD_DACLRCK  (lrck),
    .AUD_DACDAT   (dat)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock; upstream reacts to a completed handshake after the edge.
  task automatic step();
    logic a;
    a = sv & ready;
    @(posedge clk);
    #1;
    if (a) begin
      n_acc++;
      if (autoinc) begin
        sl = sl + 16'd1;
        sr = sr + 16'd1;
      end
      if (oneshot) sv = 1'b0;
    end
  endtask

  // Observe one 768-cycle frame starting at a frame-load point.
  task automatic frame(input int inj_at, input logic [31:0] inj,
                       output logic [31:0] c, output int l, output int u,
                       output int n, output int f, output int r, output int a);
    logic pb;
    int a0;
    c = '0; l = 0; u = 0; n = 0; f = -1; r = 0;
    pb = bclk;
    a0 = n_acc;
    for (int i = 0; i < 768; i++) begin
      if (i == inj_at) begin
        {sl, sr} = inj;
        sv = 1'b1;
      end
      if (lrck) l++;
      if (und_o) u++;
      if (!ready) r++;
      if (!pb && bclk) begin
        n++;
        c = {c[30:0], dat};
        if (f < 0) f = i;
      end
      pb = bclk;
      step();
    end
    a = n_acc - a0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; sv = 1'b0; sl = '0; sr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", 32'(outs), 32'h0);

    rst_n = 1'b1;
    idle_bad = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (outs != 6'd0) idle_bad++;
    end
    chk("idle_quiet", idle_bad, 0);

    // Single frame with bypass on the first load
    sl = 16'hA5C3; sr = 16'h0F01; sv = 1'b1; oneshot = 1'b1; en = 1'b1;
    step();
    chk("run_ready", 32'(ready), 32'd1);
    chk("pre_load_lrck", 32'(lrck), 32'd0);
    step();
    chk("load1_pins", 32'({bclk, lrck, dat}), 32'b011);
    chk("load1_xck", 32'(xck), 32'd1);
    chk("bypass_acc", n_acc, 1);
    frame(-1, '0, cap, lrn, und, nb, fr, rlo, acc);
    chk("f1_data", cap, 32'hA5C30F01);
    chk("f1_lrck_cycles", lrn, 384);
    chk("f1_underrun", und, 0);
    chk("f1_bits", nb, 32);
    chk("f1_first_rise", fr, 12);

    // Underrun frame
    chk("und_pulse", 32'(und_o), 32'd1);
    frame(-1, '0, cap, lrn, und, nb, fr, rlo, acc);
    chk("f2_data", cap, 32'h0);
    chk("f2_underrun", und, 1);
    chk("f2_lrck_cycles", lrn, 384);
    chk("f2_bits", nb, 32);
    chk("f2_first_rise", fr, 12);

    // Mid-frame accept fills the buffer
    frame(100, 32'h12345678, cap, lrn, und, nb, fr, rlo, acc);
    chk("f3_ready_low", rlo, 667);
    chk("f3_accepts", acc, 1);
    chk("ready_after_load", 32'(ready), 32'd1);
    chk("load4_underrun", 32'(und_o), 32'd0);

    // Throughput with a continuously valid incrementing source
    sl = 16'h0001; sr = 16'h8001; sv = 1'b1; autoinc = 1'b1; oneshot = 1'b0;
    frame(-1, '0, cap, lrn, und, nb, fr, rlo, acc);
    chk("f4_data", cap, 32'h12345678);
    chk("f4_accepts", acc, 1);
    chk("f4_underrun", und, 0);
    frame(-1, '0, cap, lrn, und, nb, fr, rlo, acc);
    chk("f5_data", cap, 32'h00018001);
    chk("f5_accepts", acc, 1);
    chk("f5_underrun", und, 0);
    frame(-1, '0, cap, lrn, und, nb, fr, rlo, acc);
    chk("f6_data", cap, 32'h00028002);
    chk("f6_accepts", acc, 1);

    // en dropped at bit 20
    repeat (490) step();
    chk("bit20_lrck", 32'(lrck), 32'd0);
    sv = 1'b0; autoinc = 1'b0; en = 1'b0;
    step();
    chk("en_abort_outs", 32'(outs), 32'h0);
    repeat (5) step();
    sl = 16'hBEEF; sr = 16'hCAFE; sv = 1'b1; oneshot = 1'b1; en = 1'b1;
    step();
    step();
    chk("reen_load_pins", 32'({bclk, lrck, dat}), 32'b011);
    frame(-1, '0, cap, lrn, und, nb, fr, rlo, acc);
    chk("f7_data", cap, 32'hBEEFCAFE);
    chk("f7_lrck_cycles", lrn, 384);

    // KEY0 asserted at bit 20
    repeat (490) step();
    rst_n = 1'b0;
    #1;
    chk("key0_abort_outs", 32'(outs), 32'h0);
    repeat (2) step();
    sl = 16'h7FFF; sr = 16'h8000; sv = 1'b1; oneshot = 1'b1;
    rst_n = 1'b1;
    step();
    step();
    chk("key0_load_pins", 32'({bclk, lrck, dat}), 32'b010);
    frame(-1, '0, cap, lrn, und, nb, fr, rlo, acc);
    chk("f8_data", cap, 32'h7FFF8000);
    chk("f8_underrun", und, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
